// File: rtl/bbqm_queue_ctrl_if.sv
// ---------------------------------------------------------------------------
// bbqm_queue_ctrl_if
// Bundles the bank-queue manager's button inputs, teller count and status
// outputs so that the top level and the bench connect with a single port.
//   master : drives arrive/depart/tcount, observes count and wait-time digits
//   slave  : the queue controller itself
// Ports (all in the bundle):
//   arrive, depart        customer buttons (asynchronous, active-high)
//   tcount[TELLER_W]      number of open tellers
//   pcount[CNT_W]         people in queue; empty / full flags
//   wtime_tens/ones[4]    BCD wait time; wtime_valid qualifies them
//   reject_arrive/depart  one-clk pulses for ignored presses
// ---------------------------------------------------------------------------
interface bbqm_queue_ctrl_if #(
  parameter int TELLER_W = 2,
  parameter int CNT_W    = 4
);
  logic                arrive;
  logic                depart;
  logic [TELLER_W-1:0] tcount;
  logic [CNT_W-1:0]    pcount;
  logic                empty;
  logic                full;
  logic [3:0]          wtime_ones;
  logic [3:0]          wtime_tens;
  logic                wtime_valid;
  logic                reject_arrive;
  logic                reject_depart;

  modport master (
    output arrive, depart, tcount,
    input  pcount, empty, full, wtime_ones, wtime_tens, wtime_valid,
           reject_arrive, reject_depart
  );

  modport slave (
    input  arrive, depart, tcount,
    output pcount, empty, full, wtime_ones, wtime_tens, wtime_valid,
           reject_arrive, reject_depart
  );
endinterface

// File: rtl/bbqm_queue_ctrl.sv
// ---------------------------------------------------------------------------
// bbqm_queue_ctrl
// Bank-queue manager: samples the arrive/depart buttons on a slow tick,
// keeps a saturating people count and computes the estimated wait time
// W = SERVICE_TIME * ceil(pcount / tcount) with a small multi-cycle FSM
// (divide by repeated subtraction, multiply by repeated addition, binary to
// BCD by repeated subtraction of ten).
// Ports:
//   clk    system clock
//   reset  synchronous, active-low
//   bus    bbqm_queue_ctrl_if.slave (buttons, tcount, count, flags, digits)
// ---------------------------------------------------------------------------
module bbqm_queue_ctrl #(
  parameter int MAX_PEOPLE   = 15,
  parameter int TELLER_W     = 2,
  parameter int SERVICE_TIME = 3,
  parameter int TICK_DIV     = 10_000_000,
  parameter int CNT_W        = 4
) (
  input  logic               clk,
  input  logic               reset,
  bbqm_queue_ctrl_if.slave   bus
);

  localparam int DW = (CNT_W > TELLER_W) ? CNT_W : TELLER_W;
  localparam int AW = 7;                       // wait time never exceeds 99
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIV  = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_BCD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // ---------------- sample tick ----------------
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // ---------------- buttons: bit0 = arrive, bit1 = depart ----------------
  logic [1:0] sync1, sync2, samp, armed, prime, ev;

  // A button only becomes armed once it has been seen released after reset
  // (and after the synchroniser has refilled), so a press held through reset
  // release produces no event until it is released and pressed again.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      samp  <= '0;
      armed <= '0;
      prime <= '0;
      ev    <= '0;
    end else begin
      sync1 <= {bus.depart, bus.arrive};
      sync2 <= sync1;
      prime <= {prime[0], 1'b1};
      ev    <= tick ? (sync2 & ~samp & armed) : 2'b00;
      if (tick) begin
        samp  <= sync2;
        armed <= armed | (~sync2 & {2{prime[1]}});
      end
    end
  end

  // ---------------- people count ----------------
  logic [CNT_W-1:0] pcount, pc_nxt;
  logic             empty, full, rej_a, rej_d, rej_a_nxt, rej_d_nxt;

  always_comb begin
    pc_nxt    = pcount;
    rej_a_nxt = 1'b0;
    rej_d_nxt = 1'b0;
    case (ev)
      2'b01: begin
        if (pcount < CNT_W'(MAX_PEOPLE)) pc_nxt = pcount + CNT_W'(1);
        else                             rej_a_nxt = 1'b1;
      end
      2'b10: begin
        if (pcount != '0) pc_nxt = pcount - CNT_W'(1);
        else              rej_d_nxt = 1'b1;
      end
      2'b11: begin
        // depart first then arrive: only the empty case changes anything
        if (pcount == '0) begin
          pc_nxt    = CNT_W'(1);
          rej_d_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcount <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      rej_a  <= 1'b0;
      rej_d  <= 1'b0;
    end else begin
      pcount <= pc_nxt;
      empty  <= (pc_nxt == '0);
      full   <= (pc_nxt == CNT_W'(MAX_PEOPLE));
      rej_a  <= rej_a_nxt;
      rej_d  <= rej_d_nxt;
    end
  end

  // ---------------- wait-time FSM ----------------
  logic [2:0]          state;
  logic [CNT_W-1:0]    p_sh;
  logic [TELLER_W-1:0] t_sh;
  logic [DW-1:0]       rem, quo, t_ext;
  logic [AW-1:0]       acc;
  logic [3:0]          tacc, ones_q, tens_q;
  logic                valid, trigger;

  assign t_ext   = DW'(t_sh);
  assign trigger = (pcount != p_sh) || (bus.tcount != t_sh);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      p_sh   <= '0;
      t_sh   <= '0;
      rem    <= '0;
      quo    <= '0;
      acc    <= '0;
      tacc   <= '0;
      ones_q <= '0;
      tens_q <= '0;
      valid  <= 1'b1;
    end else if (state == S_IDLE) begin
      if (trigger) begin
        p_sh  <= pcount;
        t_sh  <= bus.tcount;
        valid <= 1'b0;
        rem   <= DW'(pcount);
        quo   <= '0;
        acc   <= '0;
        tacc  <= '0;
        state <= S_DIV;
      end
    end else if (trigger) begin
      // inputs moved under us: drop the stale result, IDLE restarts it
      state <= S_IDLE;
    end else begin
      case (state)
        S_DIV: begin
          if (p_sh == '0 || t_sh == '0) begin
            state <= S_BCD;                    // acc already 0
          end else if (rem <= t_ext) begin
            quo   <= quo + DW'(1);             // leftover rounds up
            state <= S_MUL;
          end else begin
            rem <= rem - t_ext;
            quo <= quo + DW'(1);
          end
        end
        S_MUL: begin
          if (quo == '0) begin
            state <= S_BCD;
          end else begin
            acc <= acc + AW'(SERVICE_TIME);
            quo <= quo - DW'(1);
          end
        end
        S_BCD: begin
          if (acc >= AW'(10)) begin
            acc  <= acc - AW'(10);
            tacc <= tacc + 4'd1;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          ones_q <= acc[3:0];
          tens_q <= tacc;
          valid  <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pcount        = pcount;
  assign bus.empty         = empty;
  assign bus.full          = full;
  assign bus.reject_arrive = rej_a;
  assign bus.reject_depart = rej_d;
  assign bus.wtime_ones    = ones_q;
  assign bus.wtime_tens    = tens_q;
  assign bus.wtime_valid   = valid;

endmodule

// File: tb/tb_bbqm_queue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bbqm_queue_ctrl
// Directed scenarios followed by random button/teller activity. A reference
// model holds the people count and reject tallies as integers and computes
// the wait time as SERVICE_TIME * ceil(p / t).
// ---------------------------------------------------------------------------
module tb_bbqm_queue_ctrl;
  localparam int MAXP = 15;
  localparam int TW   = 2;
  localparam int ST   = 3;
  localparam int TDIV = 4;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic reset;

  bbqm_queue_ctrl_if #(.TELLER_W(TW), .CNT_W(CW)) bus ();

  bbqm_queue_ctrl #(
    .MAX_PEOPLE(MAXP), .TELLER_W(TW), .SERVICE_TIME(ST),
    .TICK_DIV(TDIV), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n_ra = 0, n_rd = 0;         // observed reject pulses (cycles high)
  int m_p = 0, m_t = 1, m_ra = 0, m_rd = 0;
  bit mon9 = 1'b0, saw9 = 1'b0;

  always @(negedge clk) begin
    if (bus.reject_arrive === 1'b1) n_ra++;
    if (bus.reject_depart === 1'b1) n_rd++;
    if (mon9 && bus.wtime_valid === 1'b1 && bus.wtime_tens === 4'd0 &&
        bus.wtime_ones === 4'd9) saw9 = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_w(input int p, input int t);
    if (p == 0 || t == 0) return 0;
    return ST * ((p + t - 1) / t);
  endfunction

  task automatic model_apply(input bit a, input bit d);
    if (a && d) begin
      if (m_p == 0) begin m_p = 1; m_rd++; end
    end else if (a) begin
      if (m_p < MAXP) m_p++; else m_ra++;
    end else if (d) begin
      if (m_p > 0) m_p--; else m_rd++;
    end
  endtask

  task automatic press(input bit a, input bit d, input int hold_ticks);
    @(negedge clk);
    bus.arrive = a;
    bus.depart = d;
    repeat (hold_ticks * TDIV) @(negedge clk);
    bus.arrive = 1'b0;
    bus.depart = 1'b0;
    repeat (3 * TDIV) @(negedge clk);
    model_apply(a, d);
  endtask

  task automatic settle();
    repeat (48) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    int w;
    w = model_w(m_p, m_t);
    check({tag, ".pcount"}, bus.pcount, m_p);
    check({tag, ".empty"},  bus.empty, (m_p == 0));
    check({tag, ".full"},   bus.full, (m_p == MAXP));
    check({tag, ".valid"},  bus.wtime_valid, 1);
    check({tag, ".tens"},   bus.wtime_tens, w / 10);
    check({tag, ".ones"},   bus.wtime_ones, w % 10);
    check({tag, ".rej_a"},  n_ra, m_ra);
    check({tag, ".rej_d"},  n_rd, m_rd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".pcount"}, bus.pcount, 0);
    check({tag, ".empty"},  bus.empty, 1);
    check({tag, ".full"},   bus.full, 0);
    check({tag, ".valid"},  bus.wtime_valid, 1);
    check({tag, ".tens"},   bus.wtime_tens, 0);
    check({tag, ".ones"},   bus.wtime_ones, 0);
    check({tag, ".rja"},    bus.reject_arrive, 0);
    check({tag, ".rjd"},    bus.reject_depart, 0);
  endtask

  initial begin
    int k, r, t, h;
    reset      = 1'b0;
    bus.arrive = 1'b0;
    bus.depart = 1'b0;
    bus.tcount = 2'd1;
    m_t        = 1;

    // reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    settle();
    check_all("post_reset");

    // three separate arrivals with one teller: W = 9
    repeat (3) press(1'b1, 1'b0, 3);
    settle();
    check_all("three_arrive");

    // one long hold counts once
    press(1'b1, 1'b0, 10);
    settle();
    check_all("long_hold");

    // fill to capacity with two tellers, then overflow
    bus.tcount = 2'd2;
    m_t        = 2;
    repeat (11) press(1'b1, 1'b0, 2);
    settle();
    check_all("filled");
    press(1'b1, 1'b0, 3);
    settle();
    check_all("full_reject");

    // simultaneous press at capacity leaves the count alone
    press(1'b1, 1'b1, 3);
    settle();
    check_all("both_at_full");

    // drain, depart at empty, then both at empty
    repeat (15) press(1'b0, 1'b1, 2);
    settle();
    check_all("drained");
    press(1'b0, 1'b1, 3);
    settle();
    check_all("empty_reject");
    press(1'b1, 1'b1, 3);
    settle();
    check_all("both_at_empty");

    // p=7, t=3 would give 9; tcount drops to 0 while dividing
    bus.tcount = 2'd3;
    m_t        = 3;
    repeat (5) press(1'b1, 1'b0, 2);
    settle();
    check_all("six_three_tellers");
    mon9 = 1'b1;
    @(negedge clk);
    bus.arrive = 1'b1;
    k = 0;
    while (bus.pcount !== 4'd7 && k < 64) begin @(negedge clk); k++; end
    check("abort.p7_seen", bus.pcount, 7);
    k = 0;
    while (bus.wtime_valid !== 1'b0 && k < 8) begin @(negedge clk); k++; end
    check("abort.valid_drop", bus.wtime_valid, 0);
    bus.tcount = 2'd0;
    m_t        = 0;
    repeat (8) @(negedge clk);
    bus.arrive = 1'b0;
    repeat (12) @(negedge clk);
    m_p = 7;
    settle();
    check_all("abort");
    check("abort.no_stale_9", saw9, 0);
    mon9 = 1'b0;

    // reset in the middle of the multiply, arrive held across release
    bus.tcount = 2'd1;
    m_t        = 1;
    k = 0;
    while (bus.wtime_valid !== 1'b0 && k < 8) begin @(negedge clk); k++; end
    check("mid_mul.valid_drop", bus.wtime_valid, 0);
    repeat (9) @(negedge clk);
    bus.arrive = 1'b1;
    reset      = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_mul_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_p   = 0;
    repeat (5 * TDIV) @(negedge clk);
    check("held_through_reset.pcount", bus.pcount, 0);
    bus.arrive = 1'b0;
    repeat (3 * TDIV) @(negedge clk);
    settle();
    check_all("after_reset");
    press(1'b1, 1'b0, 3);
    settle();
    check_all("repress");

    // random activity
    repeat (40) begin
      r = $urandom_range(0, 9);
      h = $urandom_range(1, 4);
      if (r < 5)       press(1'b1, 1'b0, h);
      else if (r < 8)  press(1'b0, 1'b1, h);
      else if (r == 8) press(1'b1, 1'b1, h);
      else begin
        t = $urandom_range(0, 3);
        @(negedge clk);
        bus.tcount = t[1:0];
        m_t        = t;
      end
      settle();
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
